bo_datapath: RTL and testbench

- Operative block (datapath) for a 16-bit polynomial evaluator, e.g. Pronto = A·x² + B·x + C.
- Built from three parts:
  - three load-enabled registers (R0 holds x, R1 is the intermediate "H" register, R2 is the sum/result "S" register);
  - three 4:1 multiplexers (M0 selects a coefficient, M1 and M2 select the ALU operands);
  - one add/multiply ALU.
- Sequenced entirely by an external control FSM that drives LX, LH, LS, M0, M1, M2 and H.
- Contains no state machine of its own.

---
 rtl/bo_datapath.sv | 94 +++++++++
 tb/tb_bo_datapath.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bo_datapath.sv
// Datapath for a 16-bit polynomial evaluator (A*x^2 + B*x + C).
// `define BO_OVF_FLAG_EN to add the sticky Ovf output.
module bo_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
`ifdef BO_OVF_FLAG_EN
  output logic             Ovf,
`endif
  output logic [WIDTH-1:0] Pronto
);

  logic [WIDTH-1:0] r0, r1, r2;
  logic [WIDTH-1:0] m0, m1, m2;
  logic [WIDTH-1:0] alu;

  always_comb begin
    case (M0)
      2'b00:   m0 = '0;
      2'b01:   m0 = A;
      2'b10:   m0 = B;
      default: m0 = C;
    endcase
  end

  always_comb begin
    case (M1)
      2'b00:   m1 = m0;
      2'b01:   m1 = r0;
      2'b10:   m1 = r2;
      default: m1 = r1;
    endcase
  end

  always_comb begin
    case (M2)
      2'b00:   m2 = r0;
      2'b01:   m2 = m0;
      2'b10:   m2 = r2;
      default: m2 = r1;
    endcase
  end

  always_comb begin
    alu = H ? m1 * m2 : m1 + m2;
  end

  // Each register has its own enable; operands read pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      if (LX) r0 <= x;
      if (LH) r1 <= alu;
      if (LS) r2 <= alu;
    end
  end

`ifdef BO_OVF_FLAG_EN
  logic [2*WIDTH-1:0] full;
  logic               ovf_hit;

  always_comb begin
    full = H ? (2*WIDTH)'(m1) * (2*WIDTH)'(m2)
             : (2*WIDTH)'(m1) + (2*WIDTH)'(m2);
    ovf_hit = |full[2*WIDTH-1:WIDTH];
  end

  // Sticky until reset: any truncated capture into R1/R2 sets it.
  always_ff @(posedge clk) begin
    if (rst)
      Ovf <= 1'b0;
    else if ((LH || LS) && ovf_hit)
      Ovf <= 1'b1;
  end
`endif

  assign Pronto = r2;

endmodule

// File: tb/tb_bo_datapath.sv
// Table-driven bench for bo_datapath; expected Pronto/Ovf
// are queued when a row is driven and checked after the edge.
module tb_bo_datapath;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, LX, LH, LS, H;
  logic [1:0]   M0, M1, M2;
  logic [W-1:0] A, B, C, x;
  logic [W-1:0] Pronto;
`ifdef BO_OVF_FLAG_EN
  logic         Ovf;
`endif

  always #5 clk = ~clk;

  bo_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C), .x(x),
    .M0(M0), .M1(M1), .M2(M2),
    .LX(LX), .LH(LH), .LS(LS), .H(H),
`ifdef BO_OVF_FLAG_EN
    .Ovf(Ovf),
`endif
    .Pronto(Pronto)
  );

  typedef struct {
    logic         rst, lx, lh, ls, h;
    logic [1:0]   m0, m1, m2;
    logic [W-1:0] a, b, c, xv;
    logic [W-1:0] ep;
    logic         eo;
  } vec_t;

  typedef struct {
    logic [W-1:0] ep;
    logic         eo;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(
    input logic rs, lx, lh, ls, h,
    input logic [1:0] s0, s1, s2,
    input logic [W-1:0] a, b, c, xv, ep,
    input logic eo
  );
    vec_t v;
    v.rst = rs; v.lx = lx; v.lh = lh; v.ls = ls; v.h = h;
    v.m0 = s0; v.m1 = s1; v.m2 = s2;
    v.a = a; v.b = b; v.c = c; v.xv = xv;
    v.ep = ep; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  initial begin
    rst = 1'b0; LX = 1'b0; LH = 1'b0; LS = 1'b0; H = 1'b0;
    M0 = '0; M1 = '0; M2 = '0;
    A = '0; B = '0; C = '0; x = '0;

    // reset with all loads high
    tbl.push_back(mk(1,1,1,1,0, 0,0,0, 2,2,2,2, 0,0));
    // nominal sequence, A=B=C=x=2
    tbl.push_back(mk(0,1,0,0,0, 0,0,0, 2,2,2,2, 0,0));
    tbl.push_back(mk(0,0,1,0,1, 0,1,0, 2,2,2,2, 0,0));
    tbl.push_back(mk(0,0,1,0,1, 1,0,3, 2,2,2,2, 0,0));
    tbl.push_back(mk(0,0,0,1,1, 2,0,0, 2,2,2,2, 4,0));
    tbl.push_back(mk(0,0,0,1,0, 0,2,3, 2,2,2,2, 12,0));
    tbl.push_back(mk(0,0,0,1,0, 3,0,2, 2,2,2,2, 14,0));
    // nominal sequence, x=3 A=1 B=0 C=5
    tbl.push_back(mk(0,1,0,0,0, 0,0,0, 1,0,5,3, 14,0));
    tbl.push_back(mk(0,0,1,0,1, 0,1,0, 1,0,5,3, 14,0));
    tbl.push_back(mk(0,0,1,0,1, 1,0,3, 1,0,5,3, 14,0));
    tbl.push_back(mk(0,0,0,1,1, 2,0,0, 1,0,5,3, 0,0));
    tbl.push_back(mk(0,0,0,1,0, 0,2,3, 1,0,5,3, 9,0));
    tbl.push_back(mk(0,0,0,1,0, 3,0,2, 1,0,5,3, 14,0));
    // hold: no loads while selects and H toggle
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,i[0], 2'(i), 2'(i+1), 2'(i+2),
                       16'hffff,16'h1234,16'h8000,16'h7777, 14,0));
    // multiply overflow truncates; flag sticks
    tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0,0,16'h0100, 14,0));
    tbl.push_back(mk(0,0,0,1,1, 0,1,0, 0,0,0,16'h0100, 0,1));
    tbl.push_back(mk(0,0,0,0,1, 3,1,2, 9,9,9,9, 0,1));
    // simultaneous LH/LS
    tbl.push_back(mk(0,1,0,0,0, 0,0,0, 7,0,0,3, 0,1));
    tbl.push_back(mk(0,0,1,1,0, 1,1,1, 7,0,0,3, 10,1));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1, 7,0,0,3, 0,0));
    // R1 and R0 cleared: R1+A, then R0+A; then R2 uses old value
    tbl.push_back(mk(0,0,0,1,0, 1,3,1, 7,0,0,3, 7,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,1, 7,0,0,3, 7,0));
    tbl.push_back(mk(0,0,0,1,0, 1,2,1, 7,0,0,3, 14,0));
    // R1=10 check before reset on a fresh run
    tbl.push_back(mk(0,1,0,0,0, 0,0,0, 7,0,0,3, 14,0));
    tbl.push_back(mk(0,0,1,1,0, 1,1,1, 7,0,0,3, 10,0));
    tbl.push_back(mk(0,0,0,1,0, 0,3,2, 7,0,0,3, 20,0));
    // add carry-out
    tbl.push_back(mk(0,0,0,1,0, 1,2,1, 16'hfff0,0,0,3, 16'h0004,1));

    @(negedge clk);
    foreach (tbl[i]) begin
      exp_t e;
      rst = tbl[i].rst; LX = tbl[i].lx; LH = tbl[i].lh;
      LS = tbl[i].ls; H = tbl[i].h;
      M0 = tbl[i].m0; M1 = tbl[i].m1; M2 = tbl[i].m2;
      A = tbl[i].a; B = tbl[i].b; C = tbl[i].c; x = tbl[i].xv;
      e.ep = tbl[i].ep; e.eo = tbl[i].eo;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("pronto[%0d]", i), Pronto, e.ep);
`ifdef BO_OVF_FLAG_EN
      check($sformatf("ovf[%0d]", i), W'(Ovf), W'(e.eo));
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
